// File: rtl/row_cmd_decoder_pkg.sv
// Shared command codes, FSM state encoding and framebuffer address widths
// for the row command decoder, its framebuffer and the debugger bench.
package row_cmd_decoder_pkg;

    localparam logic [7:0] CMD_ROW_LOAD   = 8'h4C;
    localparam logic [7:0] CMD_BRIGHTNESS = 8'h62;

    localparam int DEF_ROW_WIDTH      = 5;
    localparam int DEF_COL_BYTE_WIDTH = 7;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ROW_ADDR = 2'd1,
        PIXELS   = 2'd2,
        BRIGHT   = 2'd3
    } state_e;

endpackage

// File: rtl/row_cmd_decoder_timeout.sv
// Frame inactivity watchdog: counts enabled cycles without a clear and
// pulses expire on the last allowed idle cycle.
module frame_timeout_counter #(
    parameter int TICKS = 1000,
    parameter int WIDTH = 10
) (
    input  logic clk_in,
    input  logic reset,
    input  logic clear_i,
    input  logic enable_i,
    output logic expire_o
);

    logic [WIDTH-1:0] count_q, count_d;

    // A clear on the expiry cycle wins, so a late byte is never lost to the watchdog.
    assign expire_o = enable_i && !clear_i && (count_q == WIDTH'(TICKS - 1));

    // NOTE: every always_comb target gets a default first so no latch is inferred.
    always_comb begin
        count_d = count_q;
        if (clear_i || expire_o) begin
            count_d = '0;
        end else if (enable_i) begin
            count_d = count_q + 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/row_cmd_decoder.sv
// Parses 'L' row-load and 'b' brightness frames from the UART byte stream into
// framebuffer byte writes. Optional error counter: ROW_DECODER_ERRCNT_EN.
module row_cmd_decoder
    import row_cmd_decoder_pkg::*;
#(
    parameter int PIXELS_PER_ROW  = 64,
    parameter int BYTES_PER_PIXEL = 2,
    parameter int ROW_WIDTH       = DEF_ROW_WIDTH,
    parameter int COL_BYTE_WIDTH  = DEF_COL_BYTE_WIDTH,
    parameter int TIMEOUT_TICKS   = 1000,
    parameter int TIMEOUT_WIDTH   = 10
) (
    input  logic                                clk_in,
    input  logic                                reset,
    input  logic [7:0]                          rx_data,
    input  logic                                rx_data_ready,
    output logic                                ram_write_enable,
    output logic [ROW_WIDTH+COL_BYTE_WIDTH-1:0] ram_write_addr,
    output logic [7:0]                          ram_write_data,
    output logic                                row_written,
    output logic [ROW_WIDTH-1:0]                row_written_addr,
    output logic [7:0]                          brightness,
`ifdef ROW_DECODER_ERRCNT_EN
    output logic [7:0]                          error_count,
`endif
    output logic                                busy
);

    localparam logic [COL_BYTE_WIDTH-1:0] LAST_IDX =
        COL_BYTE_WIDTH'(PIXELS_PER_ROW * BYTES_PER_PIXEL - 1);

    state_e                              state_q, state_d;
    logic [ROW_WIDTH-1:0]                row_q, row_d;
    logic [COL_BYTE_WIDTH-1:0]           byte_idx_q, byte_idx_d;
    logic [7:0]                          brightness_q, brightness_d;
    logic                                wr_en_q, wr_en_d;
    logic [ROW_WIDTH+COL_BYTE_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]                          wr_data_q, wr_data_d;
    logic                                row_done_q, row_done_d;
    logic [ROW_WIDTH-1:0]                row_done_addr_q, row_done_addr_d;
    logic                                timeout_expire;

    frame_timeout_counter #(
        .TICKS (TIMEOUT_TICKS),
        .WIDTH (TIMEOUT_WIDTH)
    ) u_timeout (
        .clk_in   (clk_in),
        .reset    (reset),
        .clear_i  (rx_data_ready || (state_q == IDLE)),
        .enable_i (state_q != IDLE),
        .expire_o (timeout_expire)
    );

    always_comb begin
        state_d         = state_q;
        row_d           = row_q;
        byte_idx_d      = byte_idx_q;
        brightness_d    = brightness_q;
        wr_en_d         = 1'b0;
        wr_addr_d       = wr_addr_q;
        wr_data_d       = wr_data_q;
        row_done_d      = 1'b0;
        row_done_addr_d = row_done_addr_q;

        if (timeout_expire) begin
            state_d    = IDLE;
            byte_idx_d = '0;
        end else if (rx_data_ready) begin
            case (state_q)
                IDLE: begin
                    if (rx_data == CMD_ROW_LOAD) begin
                        state_d = ROW_ADDR;
                    end else if (rx_data == CMD_BRIGHTNESS) begin
                        state_d = BRIGHT;
                    end
                end
                ROW_ADDR: begin
                    row_d      = rx_data[ROW_WIDTH-1:0];
                    byte_idx_d = '0;
                    state_d    = PIXELS;
                end
                PIXELS: begin
                    // Write is registered: it appears on the cycle after the byte.
                    wr_en_d    = 1'b1;
                    wr_addr_d  = {row_q, byte_idx_q};
                    wr_data_d  = rx_data;
                    byte_idx_d = byte_idx_q + 1'b1;
                    if (byte_idx_q == LAST_IDX) begin
                        row_done_d      = 1'b1;
                        row_done_addr_d = row_q;
                        byte_idx_d      = '0;
                        state_d         = IDLE;
                    end
                end
                BRIGHT: begin
                    brightness_d = rx_data;
                    state_d      = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            state_q         <= IDLE;
            row_q           <= '0;
            byte_idx_q      <= '0;
            brightness_q    <= 8'hFF;
            wr_en_q         <= 1'b0;
            wr_addr_q       <= '0;
            wr_data_q       <= '0;
            row_done_q      <= 1'b0;
            row_done_addr_q <= '0;
        end else begin
            state_q         <= state_d;
            row_q           <= row_d;
            byte_idx_q      <= byte_idx_d;
            brightness_q    <= brightness_d;
            wr_en_q         <= wr_en_d;
            wr_addr_q       <= wr_addr_d;
            wr_data_q       <= wr_data_d;
            row_done_q      <= row_done_d;
            row_done_addr_q <= row_done_addr_d;
        end
    end

`ifdef ROW_DECODER_ERRCNT_EN
    logic       unknown_cmd;
    logic [7:0] err_cnt_q;

    assign unknown_cmd = rx_data_ready && (state_q == IDLE) &&
                         (rx_data != CMD_ROW_LOAD) && (rx_data != CMD_BRIGHTNESS);

    always_ff @(posedge clk_in) begin
        if (reset) begin
            err_cnt_q <= '0;
        end else if ((unknown_cmd || timeout_expire) && (err_cnt_q != 8'hFF)) begin
            err_cnt_q <= err_cnt_q + 1'b1;
        end
    end

    assign error_count = err_cnt_q;
`endif

    assign ram_write_enable = wr_en_q;
    assign ram_write_addr   = wr_addr_q;
    assign ram_write_data   = wr_data_q;
    assign row_written      = row_done_q;
    assign row_written_addr = row_done_addr_q;
    assign brightness       = brightness_q;
    assign busy             = (state_q != IDLE);

endmodule
